// File: rtl/rr_beats_arbiter_if.sv
// Bus bundle for rr_beats_arbiter: per-requester valid/ready/data on the input
// side, one registered valid/ready stream on the output side.
// RR_ARB_LOCK_EN adds last_in/last_out for packet-lock mode.
interface rr_beats_arbiter_if #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_WD   = 2
);
    logic [NUM_REQ-1:0]         valid_in;
    logic [NUM_REQ*DATA_WD-1:0] data_in;
    logic [NUM_REQ-1:0]         ready_in;
    logic                       valid_out;
    logic [DATA_WD-1:0]         data_out;
    logic [ID_WD-1:0]           id_out;
    logic                       ready_out;
`ifdef RR_ARB_LOCK_EN
    logic [NUM_REQ-1:0]         last_in;
    logic                       last_out;

    // Requesters plus downstream consumer.
    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, id_out, last_out
    );

    // Arbiter side.
    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, id_out, last_out
    );
`else
    // Requesters plus downstream consumer.
    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, id_out
    );

    // Arbiter side.
    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, id_out
    );
`endif
endinterface

// File: rtl/rr_beats_arbiter.sv
// Round-robin N-to-1 arbiter for valid/ready beat streams with a registered
// output stage tagged by source index.
// Optional packet-lock mode under macro RR_ARB_LOCK_EN: the grant is held on
// one requester until a beat with last_in set completes the packet.
module rr_beats_arbiter #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_WD   = 2
) (
    input logic              clk,
    input logic              rst_n,
    rr_beats_arbiter_if.slave bus
);

    logic [ID_WD-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic [ID_WD-1:0]   id_q, id_d;

    logic [NUM_REQ-1:0] eligible;
    logic               gnt_valid;
    logic [ID_WD-1:0]   gnt_idx;
    logic [DATA_WD-1:0] gnt_data;
    logic [NUM_REQ-1:0] ready_vec;
    logic               slot_free;
    logic               in_fire;
    logic               out_fire;

`ifdef RR_ARB_LOCK_EN
    logic               locked_q, locked_d;
    logic [ID_WD-1:0]   lock_id_q, lock_id_d;
    logic               last_q, last_d;
    logic               gnt_last;
`endif

    // (base + off) mod NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [ID_WD-1:0] wrap_add(logic [ID_WD-1:0] base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_WD-1:0];
    endfunction

    assign slot_free = !valid_q || bus.ready_out;
    assign out_fire  = valid_q && bus.ready_out;
    assign in_fire   = gnt_valid && slot_free;

`ifdef RR_ARB_LOCK_EN
    // While a packet is in flight only its owner may compete.
    always_comb begin
        eligible = bus.valid_in;
        if (locked_q) begin
            eligible = '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (lock_id_q == ID_WD'(i)) begin
                    eligible[i] = bus.valid_in[i];
                end
            end
        end
    end
`else
    assign eligible = bus.valid_in;
`endif

    // First eligible requester scanning from ptr upward with wrap.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_valid && eligible[wrap_add(ptr_q, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    // Route the granted payload and drive the one-hot ready.
    always_comb begin
        gnt_data  = '0;
        ready_vec = '0;
`ifdef RR_ARB_LOCK_EN
        gnt_last  = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_WD'(i)) begin
                gnt_data     = bus.data_in[i*DATA_WD +: DATA_WD];
                ready_vec[i] = gnt_valid && slot_free;
`ifdef RR_ARB_LOCK_EN
                gnt_last     = bus.last_in[i];
`endif
            end
        end
    end

    // Next state of the output stage, pointer and lock.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
`ifdef RR_ARB_LOCK_EN
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
`endif
        if (in_fire) begin
            valid_d = 1'b1;
            data_d  = gnt_data;
            id_d    = gnt_idx;
            ptr_d   = wrap_add(gnt_idx, 32'd1);
`ifdef RR_ARB_LOCK_EN
            last_d  = gnt_last;
            if (!gnt_last) begin
                // Mid-packet: pin the grant and keep the pointer where it was.
                locked_d  = 1'b1;
                lock_id_d = gnt_idx;
                ptr_d     = ptr_q;
            end else begin
                locked_d  = 1'b0;
            end
`endif
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
`ifdef RR_ARB_LOCK_EN
            locked_q  <= 1'b0;
            lock_id_q <= '0;
            last_q    <= 1'b0;
`endif
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
`ifdef RR_ARB_LOCK_EN
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
`endif
        end
    end

    assign bus.ready_in  = ready_vec;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.id_out    = id_q;
`ifdef RR_ARB_LOCK_EN
    assign bus.last_out  = last_q;
`endif

endmodule

// File: tb/tb_rr_beats_arbiter.sv
// Directed bench for rr_beats_arbiter: a 4-requester instance for the main
// sequences and a 3-requester instance for the non-power-of-two wrap.
// Packet-lock sequences run only when RR_ARB_LOCK_EN is defined.
module tb_rr_beats_arbiter;

    logic clk;
    logic rst_n;

    int n_total;
    int n_pass;

    rr_beats_arbiter_if #(.DATA_WD(8), .NUM_REQ(4), .ID_WD(2)) ifa ();
    rr_beats_arbiter_if #(.DATA_WD(8), .NUM_REQ(3), .ID_WD(2)) ifb ();

    rr_beats_arbiter #(.DATA_WD(8), .NUM_REQ(4), .ID_WD(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    rr_beats_arbiter #(.DATA_WD(8), .NUM_REQ(3), .ID_WD(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_b[4];
        exp_b = '{2, 1, 2, 1};
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b1;
        ifa.valid_in  = '0;
        ifa.data_in   = '0;
        ifa.ready_out = 1'b0;
        ifb.valid_in  = '0;
        ifb.data_in   = '0;
        ifb.ready_out = 1'b0;
`ifdef RR_ARB_LOCK_EN
        ifa.last_in   = '1;
        ifb.last_in   = '1;
`endif

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(ifa.valid_out), 32'd0);
        check("rst_data", 32'(ifa.data_out), 32'd0);
        check("rst_id", 32'(ifa.id_out), 32'd0);
        check("rst_ready_in", 32'(ifa.ready_in), 32'd0);
`ifdef RR_ARB_LOCK_EN
        check("rst_last", 32'(ifa.last_out), 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;

        // All four valid, sink always ready: ids 0,1,2,3,0,1 back to back
        ifa.valid_in  = 4'b1111;
        ifa.data_in   = 32'h33221100;
        ifa.ready_out = 1'b1;
        #1;
        check("rr_first_ready", 32'(ifa.ready_in), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_valid", 32'(ifa.valid_out), 32'd1);
            check("rr_id", 32'(ifa.id_out), 32'(k % 4));
            check("rr_data", 32'(ifa.data_out), 32'((k % 4) * 17));
        end
        // Drain: output fire with no input fire, data/id hold
        ifa.valid_in = '0;
        step();
        check("drain_valid", 32'(ifa.valid_out), 32'd0);
        check("drain_id_hold", 32'(ifa.id_out), 32'd1);
        check("drain_data_hold", 32'(ifa.data_out), 32'h11);

        // Lone requester 2 with 0xA5
        ifa.valid_in = 4'b0100;
        ifa.data_in  = 32'h33A51100;
        #1;
        check("solo_ready", 32'(ifa.ready_in), 32'b0100);
        step();
        check("solo_valid", 32'(ifa.valid_out), 32'd1);
        check("solo_data", 32'(ifa.data_out), 32'hA5);
        check("solo_id", 32'(ifa.id_out), 32'd2);

        // Backpressure for 5 cycles: ready_in 0, output frozen
        ifa.ready_out = 1'b0;
        ifa.valid_in  = 4'b1011;
        ifa.data_in   = 32'h335A1100;
        #1;
        check("bp_ready_in", 32'(ifa.ready_in), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 32'(ifa.valid_out), 32'd1);
            check("bp_data", 32'(ifa.data_out), 32'hA5);
            check("bp_id", 32'(ifa.id_out), 32'd2);
            check("bp_ready_in", 32'(ifa.ready_in), 32'd0);
        end
        // Release: pop and push in the same cycle; ptr=3 so requester 3 wins
        ifa.ready_out = 1'b1;
        #1;
        check("bp_release_ready", 32'(ifa.ready_in), 32'b1000);
        step();
        check("bp_next_valid", 32'(ifa.valid_out), 32'd1);
        check("bp_next_id", 32'(ifa.id_out), 32'd3);
        check("bp_next_data", 32'(ifa.data_out), 32'h33);
        step();
        check("wrap_id", 32'(ifa.id_out), 32'd0);
        check("wrap_data", 32'(ifa.data_out), 32'h00);
        step();
        check("skip_id", 32'(ifa.id_out), 32'd1);
        check("skip_data", 32'(ifa.data_out), 32'h11);
        ifa.valid_in = '0;
        step();
        check("idle_valid", 32'(ifa.valid_out), 32'd0);

        // Three requesters: move ptr to 2, then 1 and 2 valid -> 2,1,2,1
        ifb.valid_in  = 3'b010;
        ifb.data_in   = 24'h221100;
        ifb.ready_out = 1'b1;
        step();
        check("n3_setup_id", 32'(ifb.id_out), 32'd1);
        ifb.valid_in = 3'b110;
        for (int k = 0; k < 4; k++) begin
            step();
            check("n3_id", 32'(ifb.id_out), 32'(exp_b[k]));
            check("n3_data", 32'(ifb.data_out), 32'(exp_b[k] * 17));
        end
        ifb.valid_in = '0;

        // Reset mid-transfer: beat from requester 2 leaves ptr at 3
        ifa.data_in   = 32'h33221100;
        ifa.valid_in  = 4'b1100;
        ifa.ready_out = 1'b0;
        step();
        check("pre_rst_valid", 32'(ifa.valid_out), 32'd1);
        check("pre_rst_id", 32'(ifa.id_out), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifa.valid_out), 32'd0);
        check("async_rst_id", 32'(ifa.id_out), 32'd0);
        check("async_rst_data", 32'(ifa.data_out), 32'd0);
        step();
        rst_n = 1'b1;
        ifa.ready_out = 1'b1;
        #1;
        check("post_rst_ready", 32'(ifa.ready_in), 32'b0100);
        step();
        check("post_rst_id", 32'(ifa.id_out), 32'd2);
        check("post_rst_data", 32'(ifa.data_out), 32'h22);
        ifa.valid_in = '0;
        step();

`ifdef RR_ARB_LOCK_EN
        // ptr=3; requester 0 sends 3-beat packet while requester 1 waits
        ifa.valid_in = 4'b0011;
        ifa.last_in  = 4'b0010;
        #1;
        check("lk_first_ready", 32'(ifa.ready_in), 32'b0001);
        step();
        check("lk_b0_id", 32'(ifa.id_out), 32'd0);
        check("lk_b0_last", 32'(ifa.last_out), 32'd0);
        check("lk_held_ready", 32'(ifa.ready_in), 32'b0001);
        step();
        check("lk_b1_id", 32'(ifa.id_out), 32'd0);
        ifa.last_in = 4'b0011;
        step();
        check("lk_b2_id", 32'(ifa.id_out), 32'd0);
        check("lk_b2_last", 32'(ifa.last_out), 32'd1);
        step();
        check("lk_after_id", 32'(ifa.id_out), 32'd1);
        // Lock onto requester 3, then reset while held and locked
        ifa.valid_in = 4'b1001;
        ifa.last_in  = 4'b0000;
        step();
        check("lk_r3_id", 32'(ifa.id_out), 32'd3);
        ifa.ready_out = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("lk_rst_valid", 32'(ifa.valid_out), 32'd0);
        check("lk_rst_last", 32'(ifa.last_out), 32'd0);
        step();
        rst_n = 1'b1;
        ifa.ready_out = 1'b1;
        #1;
        check("lk_unlock_ready", 32'(ifa.ready_in), 32'b0001);
        step();
        check("lk_unlock_id", 32'(ifa.id_out), 32'd0);
        ifa.valid_in = '0;
        ifa.last_in  = '1;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
